// File: rtl/arbiter_req_queue_bank_if.sv
// Bundle of the queue-bank signals: the enqueue side, the request vector
// going to the arbiter, the grant coming back, and the dequeue output.
//   enq_valid_by_req / enq_data_by_req : per-requester push request and payload
//   enq_ready_by_req                   : per-requester "queue not full"
//   req_vec                            : per-requester "queue not empty"
//   ack_one_hot                        : arbiter grant
//   deq_valid / deq_data / deq_index   : entry popped this cycle
// The slave modport is the queue bank; master is whoever drives it.
interface arbiter_req_queue_bank_if #(
    parameter int REQUESTER_COUNT     = 4,
    parameter int LOG_REQUESTER_COUNT = 2,
    parameter int DATA_WIDTH          = 32
);
    logic [REQUESTER_COUNT-1:0]                 enq_valid_by_req;
    logic [REQUESTER_COUNT-1:0][DATA_WIDTH-1:0] enq_data_by_req;
    logic [REQUESTER_COUNT-1:0]                 enq_ready_by_req;
    logic [REQUESTER_COUNT-1:0]                 req_vec;
    logic [REQUESTER_COUNT-1:0]                 ack_one_hot;
    logic                                       deq_valid;
    logic [DATA_WIDTH-1:0]                      deq_data;
    logic [LOG_REQUESTER_COUNT-1:0]             deq_index;

    modport slave (
        input  enq_valid_by_req,
        input  enq_data_by_req,
        input  ack_one_hot,
        output enq_ready_by_req,
        output req_vec,
        output deq_valid,
        output deq_data,
        output deq_index
    );

    modport master (
        output enq_valid_by_req,
        output enq_data_by_req,
        output ack_one_hot,
        input  enq_ready_by_req,
        input  req_vec,
        input  deq_valid,
        input  deq_data,
        input  deq_index
    );
endinterface

// File: rtl/arbiter_req_queue_bank.sv
// Per-requester FIFO bank sitting in front of a round-robin arbiter.
// Each requester owns a QUEUE_DEPTH-entry queue; the non-empty vector is
// offered to the arbiter as req_vec, and the head of the queue named by the
// arbiter's one-hot grant is popped and forwarded in the same cycle.
// Ports:
//   clk : clock, all state updates on posedge
//   rst : asynchronous active-high reset, clears all queue pointers
//   bus : arbiter_req_queue_bank_if.slave (enqueue, req_vec, ack, dequeue)
module arbiter_req_queue_bank #(
    parameter int REQUESTER_COUNT     = 4,
    parameter int LOG_REQUESTER_COUNT = 2,
    parameter int DATA_WIDTH          = 32,
    parameter int QUEUE_DEPTH         = 4,
    parameter int LOG_QUEUE_DEPTH     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    arbiter_req_queue_bank_if.slave       bus
);
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int               PTR_W   = LOG_QUEUE_DEPTH + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [REQUESTER_COUNT-1:0] REQ_ONE = REQUESTER_COUNT'(1);

    logic [PTR_W-1:0]      rd_ptr    [REQUESTER_COUNT];
    logic [PTR_W-1:0]      wr_ptr    [REQUESTER_COUNT];
    logic [DATA_WIDTH-1:0] entry_ram [REQUESTER_COUNT][QUEUE_DEPTH];

    logic [REQUESTER_COUNT-1:0]     full;
    logic [REQUESTER_COUNT-1:0]     empty;
    logic [REQUESTER_COUNT-1:0]     push;
    logic [REQUESTER_COUNT-1:0]     pop;
    logic                           ack_is_one_hot;
    logic                           deq_fire;
    logic [LOG_REQUESTER_COUNT-1:0] ack_index;

    // Queue status comes from registered pointers only, so a push is never
    // visible in req_vec during the cycle it is made.
    always_comb begin
        full  = '0;
        empty = '0;
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            empty[i] = (rd_ptr[i] == wr_ptr[i]);
            full[i]  = (rd_ptr[i][LOG_QUEUE_DEPTH-1:0] == wr_ptr[i][LOG_QUEUE_DEPTH-1:0]) &&
                       (rd_ptr[i][LOG_QUEUE_DEPTH] != wr_ptr[i][LOG_QUEUE_DEPTH]);
        end
    end

    // x & (x-1) clears the lowest set bit; zero result on a non-zero x means
    // exactly one bit was set.
    always_comb begin
        ack_is_one_hot = (bus.ack_one_hot != '0) &&
                         ((bus.ack_one_hot & (bus.ack_one_hot - REQ_ONE)) == '0);
        ack_index = '0;
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            if (bus.ack_one_hot[i]) begin
                ack_index = LOG_REQUESTER_COUNT'(i);
            end
        end
    end

    // Multi-hot acks and acks naming an empty queue pop nothing.
    always_comb begin
        deq_fire = ack_is_one_hot && ((bus.ack_one_hot & ~empty) != '0);
        pop      = deq_fire ? bus.ack_one_hot : '0;
        push     = bus.enq_valid_by_req & ~full;
    end

    always_comb begin
        bus.enq_ready_by_req = ~full;
        bus.req_vec          = ~empty;
        bus.deq_valid        = deq_fire;
        bus.deq_index        = deq_fire ? ack_index : '0;
        bus.deq_data         = deq_fire ?
                               entry_ram[ack_index][rd_ptr[ack_index][LOG_QUEUE_DEPTH-1:0]] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REQUESTER_COUNT; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REQUESTER_COUNT; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
                end
            end
        end
    end

    // Entry storage is data only and is deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            if (push[i]) begin
                entry_ram[i][wr_ptr[i][LOG_QUEUE_DEPTH-1:0]] <= bus.enq_data_by_req[i];
            end
        end
    end
endmodule

// File: tb/tb_arbiter_req_queue_bank.sv
module tb_arbiter_req_queue_bank;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arbiter_req_queue_bank_if #(.REQUESTER_COUNT(4), .LOG_REQUESTER_COUNT(2), .DATA_WIDTH(32)) bus ();

    arbiter_req_queue_bank #(
        .REQUESTER_COUNT(4), .LOG_REQUESTER_COUNT(2), .DATA_WIDTH(32),
        .QUEUE_DEPTH(4), .LOG_QUEUE_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]       ev;
        logic [3:0][31:0] ed;
        logic [3:0]       ack;
        logic [3:0]       req;
        logic [3:0]       rdy;
        logic             vld;
        logic [31:0]      data;
        logic [1:0]       idx;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t exp_q[$];

    // Reference queue model
    logic [31:0] mdata [4][4];
    int          mhead [4];
    int          mcnt  [4];

    // Values sampled in the most recent cycle
    logic [3:0]  s_req, s_rdy;
    logic        s_vld;
    logic [31:0] s_data;
    logic [1:0]  s_idx;

    vec_t tbl [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mhead[i] = 0;
            mcnt[i]  = 0;
        end
        exp_q.delete();
    endtask

    // Applies one cycle of stimulus starting just after a posedge, checks the
    // outputs at the negedge against the model, then advances past the edge.
    task automatic do_cycle(input logic [3:0] ev, input logic [3:0][31:0] ed, input logic [3:0] ack);
        logic [3:0] e_rdy, e_req;
        logic       fire;
        int         gi;
        exp_t       e;
        bus.enq_valid_by_req = ev;
        bus.enq_data_by_req  = ed;
        bus.ack_one_hot      = ack;
        gi = 0;
        for (int i = 0; i < 4; i++) begin
            e_rdy[i] = (mcnt[i] < 4);
            e_req[i] = (mcnt[i] > 0);
            if (ack[i]) gi = i;
        end
        fire = ($countones(ack) == 1) && ((ack & e_req) != 4'b0);
        if (fire) exp_q.push_back('{idx: 2'(gi), data: mdata[gi][mhead[gi]]});
        @(negedge clk);
        s_req  = bus.req_vec;
        s_rdy  = bus.enq_ready_by_req;
        s_vld  = bus.deq_valid;
        s_data = bus.deq_data;
        s_idx  = bus.deq_index;
        check("enq_ready", 64'(s_rdy), 64'(e_rdy));
        check("req_vec", 64'(s_req), 64'(e_req));
        check("deq_valid", 64'(s_vld), 64'(fire));
        if (fire) begin
            e = exp_q.pop_front();
            check("deq_data", 64'(s_data), 64'(e.data));
            check("deq_index", 64'(s_idx), 64'(e.idx));
        end else begin
            check("deq_data_idle", 64'(s_data), 64'h0);
            check("deq_index_idle", 64'(s_idx), 64'h0);
        end
        if (fire) begin
            mhead[gi] = (mhead[gi] + 1) % 4;
            mcnt[gi]  = mcnt[gi] - 1;
        end
        for (int i = 0; i < 4; i++) begin
            if (ev[i] && e_rdy[i]) begin
                mdata[i][(mhead[i] + mcnt[i]) % 4] = ed[i];
                mcnt[i] = mcnt[i] + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] ev, input logic [31:0] d2, input logic [3:0] ack,
                                input logic [3:0] req, input logic [3:0] rdy, input logic vld,
                                input logic [31:0] data, input logic [1:0] idx);
        vec_t v;
        v.ev = ev; v.ed = '0; v.ed[2] = d2; v.ack = ack;
        v.req = req; v.rdy = rdy; v.vld = vld; v.data = data; v.idx = idx;
        return v;
    endfunction

    logic [3:0][31:0] ed;
    logic [3:0]       ack;
    int               rr_ptr;

    initial begin
        // Fill queue 2, try a fifth push, then drain it, then ack it while empty.
        tbl[0]  = mk(4'b0100, 32'hA0, 4'b0000, 4'b0000, 4'b1111, 1'b0, 32'h0,  2'd0);
        tbl[1]  = mk(4'b0100, 32'hA1, 4'b0000, 4'b0100, 4'b1111, 1'b0, 32'h0,  2'd0);
        tbl[2]  = mk(4'b0100, 32'hA2, 4'b0000, 4'b0100, 4'b1111, 1'b0, 32'h0,  2'd0);
        tbl[3]  = mk(4'b0100, 32'hA3, 4'b0000, 4'b0100, 4'b1111, 1'b0, 32'h0,  2'd0);
        tbl[4]  = mk(4'b0100, 32'hA4, 4'b0000, 4'b0100, 4'b1011, 1'b0, 32'h0,  2'd0);
        tbl[5]  = mk(4'b0000, 32'h0,  4'b0100, 4'b0100, 4'b1011, 1'b1, 32'hA0, 2'd2);
        tbl[6]  = mk(4'b0000, 32'h0,  4'b0100, 4'b0100, 4'b1111, 1'b1, 32'hA1, 2'd2);
        tbl[7]  = mk(4'b0000, 32'h0,  4'b0100, 4'b0100, 4'b1111, 1'b1, 32'hA2, 2'd2);
        tbl[8]  = mk(4'b0000, 32'h0,  4'b0100, 4'b0100, 4'b1111, 1'b1, 32'hA3, 2'd2);
        tbl[9]  = mk(4'b0000, 32'h0,  4'b0000, 4'b0000, 4'b1111, 1'b0, 32'h0,  2'd0);
        tbl[10] = mk(4'b0000, 32'h0,  4'b0100, 4'b0000, 4'b1111, 1'b0, 32'h0,  2'd0);

        rst = 1'b1;
        bus.enq_valid_by_req = '0;
        bus.enq_data_by_req  = '0;
        bus.ack_one_hot      = '0;
        model_clear();
        #2;
        check("rst_ready", 64'(bus.enq_ready_by_req), 64'hF);
        check("rst_req_vec", 64'(bus.req_vec), 64'h0);
        check("rst_deq_valid", 64'(bus.deq_valid), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Asynchronous reset in the middle of a cycle with a pending pop.
        ed = '0; ed[0] = 32'h55;
        do_cycle(4'b0001, ed, 4'b0000);
        bus.enq_valid_by_req = '0;
        bus.ack_one_hot      = 4'b0001;
        #1;
        check("pre_rst_deq_valid", 64'(bus.deq_valid), 64'h1);
        check("pre_rst_deq_data", 64'(bus.deq_data), 64'h55);
        rst = 1'b1;
        #1;
        check("async_rst_ready", 64'(bus.enq_ready_by_req), 64'hF);
        check("async_rst_req_vec", 64'(bus.req_vec), 64'h0);
        check("async_rst_deq_valid", 64'(bus.deq_valid), 64'h0);
        check("async_rst_deq_data", 64'(bus.deq_data), 64'h0);
        check("async_rst_deq_index", 64'(bus.deq_index), 64'h0);
        bus.ack_one_hot = '0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_ready", 64'(bus.enq_ready_by_req), 64'hF);
        check("post_rst_req_vec", 64'(bus.req_vec), 64'h0);

        // Table: fill, overflow, drain, empty ack on queue 2.
        for (int k = 0; k < 11; k++) begin
            do_cycle(tbl[k].ev, tbl[k].ed, tbl[k].ack);
            check($sformatf("tbl%0d_req_vec", k), 64'(s_req), 64'(tbl[k].req));
            check($sformatf("tbl%0d_ready", k), 64'(s_rdy), 64'(tbl[k].rdy));
            check($sformatf("tbl%0d_deq_valid", k), 64'(s_vld), 64'(tbl[k].vld));
            check($sformatf("tbl%0d_deq_data", k), 64'(s_data), 64'(tbl[k].data));
            check($sformatf("tbl%0d_deq_index", k), 64'(s_idx), 64'(tbl[k].idx));
        end

        // Wrap-around on queue 1: three pushes, three push+pop, three pops.
        for (int k = 0; k < 9; k++) begin
            ed = '0;
            ed[1] = 32'h10 + 32'(k);
            ack = (k >= 3) ? 4'b0010 : 4'b0000;
            do_cycle((k < 6) ? 4'b0010 : 4'b0000, ed, ack);
            if (k >= 3) check($sformatf("wrap_pop%0d", k - 3), 64'(s_data), 64'h10 + 64'(k - 3));
        end
        do_cycle(4'b0000, '0, 4'b0000);
        check("wrap_empty", 64'(s_req), 64'h0);

        // Illegal acks: empty queue 0, then multi-hot over two loaded queues.
        do_cycle(4'b0000, '0, 4'b0001);
        check("ack_empty_no_deq", 64'(s_vld), 64'h0);
        ed = '0; ed[1] = 32'h71; ed[2] = 32'h72;
        do_cycle(4'b0110, ed, 4'b0000);
        do_cycle(4'b0000, '0, 4'b0110);
        check("multihot_no_deq", 64'(s_vld), 64'h0);
        check("multihot_req_vec", 64'(s_req), 64'h6);
        do_cycle(4'b0000, '0, 4'b0010);
        check("after_multihot_q1", 64'(s_data), 64'h71);
        do_cycle(4'b0000, '0, 4'b0100);
        check("after_multihot_q2", 64'(s_data), 64'h72);

        // Round-robin arbiter loop over two entries in every queue.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) ed[i] = 32'h100 * 32'(i + 1) + 32'(k);
            do_cycle(4'b1111, ed, 4'b0000);
        end
        rr_ptr = 0;
        for (int c = 0; c < 8; c++) begin
            ack = '0;
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (rr_ptr + k) % 4;
                if (ack == 4'b0000 && mcnt[j] > 0) begin
                    ack[j] = 1'b1;
                    rr_ptr = (j + 1) % 4;
                end
            end
            do_cycle(4'b0000, '0, ack);
            check($sformatf("rr_order%0d", c), 64'(s_idx), 64'(c % 4));
            check($sformatf("rr_data%0d", c), 64'(s_data), 64'h100 * 64'((c % 4) + 1) + 64'(c / 4));
        end
        do_cycle(4'b0000, '0, 4'b0000);
        check("rr_drained", 64'(s_req), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
